// File: rtl/regfile_arbiter.sv
`timescale 1ns/1ps
// regfile_arbiter
// Round-robin arbiter/sequencer placing two requesters (A, B) in front of a
// single-ported 8 x 8 register file. Each accepted request runs a fixed
// four-state sequence IDLE -> ISSUE -> CAPT -> DONE. The register file
// therefore never sees wr and rd together. The result is returned on the
// winning requester's own response strobe.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   req_/we_/addr_/wdata_a|b request channel per requester
//   gnt_a|b                  one-cycle grant (request fields captured)
//   rsp_valid_a|b            one-cycle response strobe
//   rdata, rsp_err           response payload, held until the next capture
//   rf_din, rf_addr, rf_wr, rf_rd   command to the register file
//   rf_dout, rf_error        registered result from the register file
module regfile_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rsp_valid_a,
  output logic              rsp_valid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rf_din,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_wr,
  output logic              rf_rd,
  input  logic [DATA_W-1:0] rf_dout,
  input  logic              rf_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  // Requester encoding used for last/owner
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t              state;
  logic                last;
  logic                owner;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

  logic                win_valid;
  logic                win;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  // Winner selection. Under contention, the requester that did not win last time gets the grant.
  // This is consumed only in IDLE, and only into registers, so no
  // combinational path reaches an output.
  always_comb begin
    win_valid = req_a | req_b;
    win       = SEL_A;
    if (req_a && req_b) begin
      win = ~last;
    end else if (req_b) begin
      win = SEL_B;
    end
    win_we    = (win == SEL_B) ? we_b    : we_a;
    win_addr  = (win == SEL_B) ? addr_b  : addr_a;
    win_wdata = (win == SEL_B) ? wdata_b : wdata_a;
  end

  // The command registers drive the register file address/data directly;
  // they only change when a new request is accepted.
  assign rf_addr = cmd_addr;
  assign rf_din  = cmd_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= SEL_B;
      owner       <= SEL_A;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      rsp_valid_a <= 1'b0;
      rsp_valid_b <= 1'b0;
      rdata       <= '0;
      rsp_err     <= 1'b0;
      rf_wr       <= 1'b0;
      rf_rd       <= 1'b0;
    end else begin
      // Strobes are single-cycle by default
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      rsp_valid_a <= 1'b0;
      rsp_valid_b <= 1'b0;
      rf_wr       <= 1'b0;
      rf_rd       <= 1'b0;

      case (state)
        IDLE: begin
          if (win_valid) begin
            owner     <= win;
            last      <= win;
            cmd_we    <= win_we;
            cmd_addr  <= win_addr;
            cmd_wdata <= win_wdata;
            // Outputs for the ISSUE cycle are set up here so that they are registered.
            gnt_a     <= (win == SEL_A);
            gnt_b     <= (win == SEL_B);
            rf_wr     <= win_we;
            rf_rd     <= ~win_we;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPT;
        end
        CAPT: begin
          // The register file's registered result for the ISSUE command is present now.
          rdata       <= cmd_we ? '0 : rf_dout;
          rsp_err     <= rf_error;
          rsp_valid_a <= (owner == SEL_A);
          rsp_valid_b <= (owner == SEL_B);
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port round-robin arbiter and sequencer in front of the 8-entry x 8-bit `register_file`. It accepts single-word read/write requests from two requesters, A and B. It serializes them onto the register file's exclusive wr/rd port and never issues wr and rd together. It returns each result on the requester's own response port, so each requester sees a simple request/grant/response protocol.

## Interface
- DATA_W, 8, data width; matches register file word
- ADDR_W, 3, address width; matches register file depth (8)
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_a / req_b  in  1  request from requester A / B
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_W  target address
- wdata_a / wdata_b  in  DATA_W  write data
- gnt_a / gnt_b  out  1  one-cycle grant pulse; request fields have been captured
- rsp_valid_a / rsp_valid_b  out  1  one-cycle response pulse
- rdata  out  DATA_W  read data; valid with rsp_valid_*; 0 for writes
- rsp_err  out  1  register file error flag captured with the response
- rf_din  out  DATA_W  to register file din
- rf_addr  out  ADDR_W  to register file addr
- rf_wr  out  1  to register file wr
- rf_rd  out  1  to register file rd
- rf_dout  in  DATA_W  from register file dout
- rf_error  in  1  from register file error

## Operation
- FSM states: IDLE, ISSUE, CAPT, DONE.
- **IDLE**
  - Sample req_a/req_b.
  - If neither is set, stay in IDLE.
  - If exactly one is set, that requester wins.
  - If both are set, the requester not equal to `last` wins. `last` resets to B, so A wins the first contention.
  - On a win: latch we/addr/wdata of the winner into cmd registers, record the winner in `owner`, set `last` <= winner, go to ISSUE.
- **ISSUE**
  - gnt_<owner> = 1.
  - rf_addr/rf_din driven from the cmd registers.
  - Exactly one of rf_wr (cmd_we = 1) or rf_rd (cmd_we = 0) is high.
  - Go to CAPT.
- **CAPT**
  - rf_wr = rf_rd = 0.
  - The register file's registered dout/error for the ISSUE command is visible this cycle.
  - Latch rdata <= (cmd_we ? 0 : rf_dout) and rsp_err <= rf_error.
  - Go to DONE.
- **DONE**
  - rsp_valid_<owner> = 1; rdata and rsp_err are held.
  - Go to IDLE.
- rf_wr and rf_rd are never both 1, so rf_error = 1 indicates an external fault. It is passed through on rsp_err and is not acted on.
- A read of a never-written address returns 0; this is register file behaviour and is passed through unchanged.
- req is level-sampled only in IDLE.
  - A requester must drop req in the cycle after its gnt, or it is treated as a new request.
  - Changes to the request fields after gnt have no effect.
- rdata and rsp_err hold their last value until the next CAPT.
- The register file's own reset is separate. This block's reset does not clear register file contents.

## Timing
- Reset (synchronous, reset = 1 at a clk edge) forces the following, regardless of state (including mid-ISSUE):
  - state = IDLE, last = B, owner = A, cmd registers = 0.
  - All outputs 0: gnt_*, rsp_valid_*, rdata, rsp_err, rf_din, rf_addr, rf_wr, rf_rd.
- A request aborted by reset gets no gnt or rsp if reset arrives in the IDLE sample cycle, and gets no rsp if reset arrives after ISSUE.
- Latency, with req sampled high in IDLE at cycle N:
  - gnt and rf_wr/rf_rd in cycle N+1.
  - rsp_valid and rdata in cycle N+3.
  - Back in IDLE at N+4.
- Throughput is one operation per 4 cycles.
- A back-to-back request from the other requester that has been held since cycle N is granted at N+5.
- All outputs are registered or decoded from state only. No combinational path from req_* to any output.

## Test plan
- Reset then single write: reset 2 cycles; A writes 0x5A to addr 3 → gnt_a at N+1 with rf_wr = 1, rf_addr = 3, rf_din = 0x5A, rf_rd = 0; rsp_valid_a at N+3 with rdata = 0, rsp_err = 0.
- Read back: B reads addr 3 → rf_rd = 1 at N+1; rsp_valid_b at N+3 with rdata = 0x5A. Reading unwritten addr 6 → rdata = 0x00.
- Contention fairness: req_a and req_b both held high continuously, A issuing, B issuing → grants alternate A, B, A, B (first is A); 4 cycles between consecutive gnts; rf_wr and rf_rd never both 1.
- Grant hold-off: A keeps req_a high after gnt_a with B idle → A is re-granted at N+5 with its current fields; a request raised during ISSUE/CAPT/DONE waits for IDLE.
- Reset mid-operation: assert reset in the CAPT cycle of a read → next cycle all outputs 0, no rsp_valid; a subsequent contention grants A first.
- Error passthrough: model forces rf_error = 1 during CAPT → rsp_err = 1 with rsp_valid in DONE; the next clean op returns rsp_err = 0.
